// File: rtl/stack_cmd_sequencer.sv
// Command front-end for the 8-entry stack FSM: buffers push/pop commands in a small FIFO
// and issues them as guarded single-cycle strobes, dropping illegal ones into sticky flags.
module stack_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  input  logic                     cmd_op,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     cmd_ready,
  input  logic                     clr_err,
  output logic                     PushEnbl,
  output logic                     PopEnbl,
  output logic [DATA_W-1:0]        push_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ovf_err,
  output logic                     udf_err,
  output logic                     busy
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QDEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // Occupancy only moves by one per cycle and is clamped to 0..DEPTH.
  function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] occ,
                                                 input logic inc, input logic dec);
    logic [OCC_W-1:0] r;
    r = occ;
    if (inc && occ < OCC_FULL)
      r = occ + OCC_W'(1);
    else if (dec && occ != '0)
      r = occ - OCC_W'(1);
    return r;
  endfunction

  logic [DATA_W-1:0] data_mem [QDEPTH];
  logic              op_mem   [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic              enq;
  logic              vld_p0;
  logic              head_op_p0;
  logic [DATA_W-1:0] head_data_p0;
  logic              push_ok_p0;
  logic              pop_ok_p0;
  logic              ovf_set_p0;
  logic              udf_set_p0;

  assign cmd_ready = (fifo_cnt < Q_FULL);
  assign busy      = (fifo_cnt != '0);
  assign enq       = cmd_valid && cmd_ready;

  // Stage p0: head of FIFO is evaluated against the committed occupancy.
  always_comb begin
    vld_p0       = (fifo_cnt != '0);
    head_op_p0   = op_mem[rd_ptr];
    head_data_p0 = data_mem[rd_ptr];
    push_ok_p0   = 1'b0;
    pop_ok_p0    = 1'b0;
    ovf_set_p0   = 1'b0;
    udf_set_p0   = 1'b0;
    if (vld_p0) begin
      if (!head_op_p0) begin
        push_ok_p0 = (occupancy < OCC_FULL);
        ovf_set_p0 = !push_ok_p0;
      end else begin
        pop_ok_p0  = (occupancy != '0);
        udf_set_p0 = !pop_ok_p0;
      end
    end
  end

  // Payload storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[wr_ptr] <= cmd_data;
      op_mem[wr_ptr]   <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (vld_p0)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, vld_p0})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Stage p1: registered strobes, payload, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PushEnbl  <= 1'b0;
      PopEnbl   <= 1'b0;
      push_data <= '0;
      occupancy <= '0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else begin
      PushEnbl  <= push_ok_p0;
      PopEnbl   <= pop_ok_p0;
      if (push_ok_p0)
        push_data <= head_data_p0;
      occupancy <= occ_step(occupancy, push_ok_p0, pop_ok_p0);
      ovf_err   <= ovf_set_p0 || (ovf_err && !clr_err);
      udf_err   <= udf_set_p0 || (udf_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench for stack_cmd_sequencer: a vector table for single-step behaviour plus
// hand-written sequences for async reset and a streaming alternating push/pop run.
module tb_stack_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       clr_err;
  logic       PushEnbl;
  logic       PopEnbl;
  logic [7:0] push_data;
  logic [3:0] occupancy;
  logic       ovf_err;
  logic       udf_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  stack_cmd_sequencer #(.DATA_W(8), .DEPTH(8), .QDEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .clr_err(clr_err),
    .PushEnbl(PushEnbl), .PopEnbl(PopEnbl), .push_data(push_data),
    .occupancy(occupancy), .ovf_err(ovf_err), .udf_err(udf_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       op;
    logic [7:0] data;
    logic       clr;
    logic       e_ready;
    logic       e_push;
    logic       e_pop;
    logic [7:0] e_pdata;
    logic [3:0] e_occ;
    logic       e_ovf;
    logic       e_udf;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic op, input logic [7:0] d, input logic clr,
                     input logic push, input logic pop, input logic [7:0] pd,
                     input logic [3:0] occ, input logic ovf, input logic udf, input logic bsy);
    vec_t t;
    t.valid = v; t.op = op; t.data = d; t.clr = clr;
    t.e_ready = 1'b1; t.e_push = push; t.e_pop = pop; t.e_pdata = pd;
    t.e_occ = occ; t.e_ovf = ovf; t.e_udf = udf; t.e_busy = bsy;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Expectations are the outputs just after the edge that consumes each row's inputs.
    //   v  op d      clr push pop pdata occ ovf udf busy
    add(1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1);  // pop on empty accepted
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0);  // dropped -> udf
    add(1, 0, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 1, 1);  // push A5 accepted
    add(0, 0, 8'h00, 0, 1, 0, 8'hA5, 1, 0, 1, 0);  // PushEnbl, 2 edges after accept
    add(0, 0, 8'h00, 1, 0, 0, 8'hA5, 1, 0, 0, 0);  // strobe gone, udf cleared
    add(1, 1, 8'h00, 0, 0, 0, 8'hA5, 1, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(1, 0, 8'(k), 0, k > 1, 0, (k > 1) ? 8'(k - 1) : 8'hA5, 4'(k - 1), 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h08, 8, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h08, 8, 0, 0, 0);
    add(1, 0, 8'h09, 0, 0, 0, 8'h08, 8, 0, 0, 1);  // 9th push at full
    add(0, 0, 8'h00, 0, 0, 0, 8'h08, 8, 1, 0, 0);  // dropped -> ovf
    add(0, 0, 8'h00, 1, 0, 0, 8'h08, 8, 0, 0, 0);
    add(1, 0, 8'h0A, 0, 0, 0, 8'h08, 8, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h08, 8, 1, 0, 0);  // set and clear coincide: set wins
    add(0, 0, 8'h00, 1, 0, 0, 8'h08, 8, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h08, 8, 0, 0, 0);

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {PushEnbl, PopEnbl, push_data, occupancy, ovf_err, udf_err, busy}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cmd_valid = vecs[i].valid; cmd_op = vecs[i].op;
      cmd_data = vecs[i].data; clr_err = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", i), cmd_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_push", i), PushEnbl, vecs[i].e_push);
      chk($sformatf("v%0d_pop", i), PopEnbl, vecs[i].e_pop);
      chk($sformatf("v%0d_pdata", i), push_data, vecs[i].e_pdata);
      chk($sformatf("v%0d_occ", i), occupancy, vecs[i].e_occ);
      chk($sformatf("v%0d_ovf", i), ovf_err, vecs[i].e_ovf);
      chk($sformatf("v%0d_udf", i), udf_err, vecs[i].e_udf);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Async reset mid-stream: pops streaming from a full stack.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ar_pre_pop", PopEnbl, 1);
    chk("ar_pre_occ", occupancy, 6);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_pop", PopEnbl, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pdata", push_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ar_post%0d", c), {PushEnbl, PopEnbl, occupancy, udf_err, busy}, 0);
    end

    // Alternating push/pop stream: command j is visible as a strobe after edge j+1.
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = j[0]; cmd_data = 8'(j + 16);
      @(posedge clk);
      #1;
      chk($sformatf("alt%0d_ready", j), cmd_ready, 1);
      if (j > 0) begin
        chk($sformatf("alt%0d_excl", j), PushEnbl & PopEnbl, 0);
        chk($sformatf("alt%0d_push", j), PushEnbl, (j - 1) % 2 == 0);
        chk($sformatf("alt%0d_pop", j), PopEnbl, (j - 1) % 2 == 1);
        chk($sformatf("alt%0d_occ", j), occupancy, ((j - 1) % 2 == 0) ? 1 : 0);
        if ((j - 1) % 2 == 0)
          chk($sformatf("alt%0d_pdata", j), push_data, j - 1 + 16);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("alt_last_pop", {PushEnbl, PopEnbl}, 2'b01);
    chk("alt_last_occ", occupancy, 0);
    @(posedge clk);
    #1;
    chk("alt_idle", {PushEnbl, PopEnbl, occupancy, ovf_err, udf_err, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
